// File: rtl/gray_to_bin.sv
// Registered Gray-to-binary converter for CDC pointer recovery, parameterised width.
// Define GRAY2BIN_PIPE_EN to split the XOR prefix chain over two register stages (2-cycle latency).
module gray_to_bin #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] gray_in,
  output logic [DATA_WIDTH-1:0] binary_out,
  output logic                  valid_out
);

`ifdef GRAY2BIN_PIPE_EN

  // Lower floor(N/2) bits are resolved in stage 2; stage 1 resolves the upper ceil(N/2).
  localparam int LO = DATA_WIDTH / 2;

  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_next;
  logic [DATA_WIDTH-1:0] s2_next;

  always_comb begin
    s1_next = gray_in;
    for (int i = DATA_WIDTH - 2; i >= LO; i--) begin
      s1_next[i] = s1_next[i+1] ^ gray_in[i];
    end
  end

  always_comb begin
    s2_next = s1_data;
    for (int i = LO - 1; i >= 0; i--) begin
      s2_next[i] = s2_next[i+1] ^ s1_data[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= en;
      if (en) begin
        s1_data <= s1_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      binary_out <= '0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        binary_out <= s2_next;
      end
    end
  end

`else

  logic [DATA_WIDTH-1:0] bin_next;

  always_comb begin
    bin_next = gray_in;
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      bin_next[i] = bin_next[i+1] ^ gray_in[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      binary_out <= '0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= en;
      if (en) begin
        binary_out <= bin_next;
      end
    end
  end

`endif

endmodule

// File: tb/tb_gray_to_bin.sv
// Self-checking bench for gray_to_bin: widths 1, 8 and 16 run side by side on shared clk/rst/en.
// Expected results are hand-computed table entries delayed through a latency-deep queue.
module tb_gray_to_bin;

`ifdef GRAY2BIN_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [0:0]  g1,  b1;
  logic [7:0]  g8,  b8;
  logic [15:0] g16, b16;
  logic        v1, v8, v16;

  always #5 clk = ~clk;

  gray_to_bin #(.DATA_WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .en(en), .gray_in(g1), .binary_out(b1), .valid_out(v1)
  );
  gray_to_bin #(.DATA_WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .en(en), .gray_in(g8), .binary_out(b8), .valid_out(v8)
  );
  gray_to_bin #(.DATA_WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .en(en), .gray_in(g16), .binary_out(b16), .valid_out(v16)
  );

  typedef struct {
    logic        en;
    logic [0:0]  g1;
    logic [0:0]  b1;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] g16;
    logic [15:0] b16;
  } vec_t;

  typedef struct {
    logic        v;
    logic [0:0]  b1;
    logic [7:0]  b8;
    logic [15:0] b16;
  } exp_t;

  exp_t        pipe_q[$];
  logic        mv;
  logic [0:0]  m1;
  logic [7:0]  m8;
  logic [15:0] m16;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[9];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("valid_w1",  {15'd0, v1},  {15'd0, mv});
    checkOutput("bin_w1",    {15'd0, b1},  {15'd0, m1});
    checkOutput("valid_w8",  {15'd0, v8},  {15'd0, mv});
    checkOutput("bin_w8",    {8'd0, b8},   {8'd0, m8});
    checkOutput("valid_w16", {15'd0, v16}, {15'd0, mv});
    checkOutput("bin_w16",   b16,          m16);
  endtask

  task automatic resetModel();
    exp_t idle;
    idle = '{v: 1'b0, b1: 1'b0, b8: 8'h00, b16: 16'h0000};
    pipe_q.delete();
    for (int i = 0; i < LAT - 1; i++) pipe_q.push_back(idle);
    mv  = 1'b0;
    m1  = 1'b0;
    m8  = 8'h00;
    m16 = 16'h0000;
  endtask

  // Drive one cycle of inputs, advance past the edge, retire the result due now, compare.
  task automatic applyStimulus(input logic e, input logic [0:0] x1, input logic [7:0] x8,
                               input logic [15:0] x16, input logic [0:0] e1,
                               input logic [7:0] e8, input logic [15:0] e16);
    exp_t o;
    en  = e;
    g1  = x1;
    g8  = x8;
    g16 = x16;
    @(posedge clk);
    #1;
    pipe_q.push_back('{v: e, b1: e1, b8: e8, b16: e16});
    o = pipe_q.pop_front();
    if (o.v) begin
      m1  = o.b1;
      m8  = o.b8;
      m16 = o.b16;
    end
    mv = o.v;
    checkAll();
  endtask

  initial begin
    logic [7:0] gn;
    logic [7:0] nb;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h55, 8'h66, 16'h8000, 16'hFFFF};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h57, 8'h65, 16'hC000, 16'h8000};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h53, 8'h62, 16'h0055, 16'h0066};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h5B, 8'h6D, 16'h0057, 16'h0065};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h73, 8'h5D, 16'hFFFF, 16'hAAAA};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 16'h0000};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 8'h80, 8'hFF, 16'h0001, 16'h0001};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'hAA, 16'h8000, 16'hFFFF};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 16'hC000, 16'h8000};

    rst = 1'b1;
    en  = 1'b0;
    g1  = 1'b0;
    g8  = 8'h00;
    g16 = 16'h0000;
    resetModel();
    #1;
    checkAll();
    @(posedge clk);
    #1;
    rst = 1'b0;
    resetModel();

    $display("[TB] directed and boundary vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].en, vecs[i].g1, vecs[i].g8, vecs[i].g16,
                    vecs[i].b1, vecs[i].b8, vecs[i].b16);
    end

    $display("[TB] hold with en low");
    applyStimulus(1'b1, 1'b1, 8'h57, 16'h0057, 1'b1, 8'h65, 16'h0065);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'($urandom), 8'($urandom), 16'($urandom), 1'b0, 8'h00, 16'h0000);
    end
    checkOutput("hold_value_w8", {8'd0, b8}, 16'h0065);

    $display("[TB] exhaustive round trip");
    for (int n = 0; n < 256; n++) begin
      nb = 8'(n);
      gn = nb ^ (nb >> 1);
      applyStimulus(1'b1, gn[0], gn, {8'h00, gn}, gn[0], nb, {8'h00, nb});
    end
    for (int i = 0; i < LAT; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000);
    end

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1'b1, 1'b1, 8'h80, 16'h8000, 1'b1, 8'hFF, 16'hFFFF);
    applyStimulus(1'b1, 1'b1, 8'hFF, 16'hFFFF, 1'b1, 8'hAA, 16'hAAAA);
    checkOutput("pre_reset_valid_w8", {15'd0, v8}, 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    resetModel();
    checkAll();
    en = 1'b0;
    @(posedge clk);
    #1;
    checkAll();
    rst = 1'b0;
    resetModel();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h33, 16'h1234, 1'b0, 8'h00, 16'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_to_bin.md
Name:
gray_to_bin

Overview:
- Registered Gray-code to binary converter, parameterised width.
- Sits on the receive side of clock-domain-crossing counters, e.g. FIFO read/write pointers, to recover binary counts for arithmetic.
- Input sampled on `en`; converted value is presented on a registered output with a qualifying valid flag.

Parameters:
- DATA_WIDTH, default 8: width of the Gray input and the binary output in bits. Legal values are 1 to 64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample enable; gray_in is captured on a rising clk edge while en=1.
- gray_in  input  DATA_WIDTH  Gray-coded value.
- binary_out  output  DATA_WIDTH  registered binary equivalent of the last sampled gray_in.
- valid_out  output  1  high for exactly one cycle when binary_out holds a newly converted value.

Interface: one clock (clk); reset rst is asynchronous and active-high.

Behaviour:
- Conversion rule, for width N = DATA_WIDTH:
  - binary[N-1] = gray[N-1]
  - binary[i] = binary[i+1] XOR gray[i], for i = N-2 down to 0
  - Equivalently, binary[i] is the XOR of gray[N-1:i].
- Pure bitwise logic: no carries, no saturation, no sign handling. Output width equals input width.
- Reset: while rst=1, binary_out is 0 and valid_out is 0, asynchronously and without waiting for clk. The first capture is the first rising edge with en=1 after rst is released.
- Latency (default build): 1 cycle.
  - gray_in is sampled at rising edge k when en=1.
  - binary_out and valid_out=1 are visible after edge k.
  - valid_out returns to 0 after edge k+1 unless en=1 again at edge k+1.
- en=0: binary_out holds its last value and valid_out=0. The block does not recompute from the live gray_in.
- Back-to-back en=1: one result per cycle, full throughput, no stall or backpressure.
- DATA_WIDTH=1: binary_out = gray_in (registered).
- Reset asserted mid-stream: any pending result is discarded, and outputs go to 0 immediately. No result appears for samples taken before reset.
- No X-propagation masking: an unknown bit in gray_in may corrupt bits at and below its position only.

Optional Feature:
- Macro: GRAY2BIN_PIPE_EN.
- Defined:
  - The XOR prefix chain is split into two register stages. Stage 1 resolves the upper ceil(N/2) bits and registers them, together with the lower Gray bits and a valid bit. Stage 2 resolves the lower bits.
  - Latency becomes 2 cycles; throughput stays 1 result per cycle.
  - valid_out is asserted 2 edges after the en=1 sample.
  - Reset clears both stages asynchronously.
  - Intended for DATA_WIDTH > 32 timing closure.
- Undefined: single-stage behaviour as above, with 1-cycle latency.
- Conversion results are identical in both builds.

Test Plan:
- Reset check: assert rst mid-operation with valid_out=1 -> binary_out=0x00 and valid_out=0 immediately, without a clk edge. After release with en=0 -> both stay 0.
- Directed values, DATA_WIDTH=8, en=1 each cycle:
  - gray 0x55 -> 0x66
  - gray 0x57 -> 0x65
  - gray 0x53 -> 0x62
  - gray 0x5B -> 0x6D
  - gray 0x73 -> 0x5D
  - Each result appears at the next edge (second edge with GRAY2BIN_PIPE_EN), with valid_out=1 every cycle.
- Boundary values: gray 0x00 -> 0x00; 0x80 -> 0xFF; 0xFF -> 0xAA; 0x01 -> 0x01.
- Hold behaviour: sample 0x57 with en=1, then en=0 for 3 cycles while gray_in toggles randomly -> binary_out stays 0x65 and valid_out is 1 for one cycle only.
- Exhaustive round trip: feed bin2gray(n) = n XOR (n>>1) for n = 0..255 back-to-back -> binary_out = n in order, with no gaps in valid_out.
- Width sweep: DATA_WIDTH=1 (0->0, 1->1) and DATA_WIDTH=16 (gray 0x8000 -> 0xFFFF; 0xC000 -> 0x8000), in both macro builds.
